gpio_msg_axis: RTL and testbench
================================

Name: gpio_msg_axis

Overview:
Generalised GPIO change reporter. It debounces a parametrised-width GPIO bus and detects value changes. Each change is sent as one framed ASCII/raw message on an 8-bit AXI-Stream master: prefix string, formatted value, optional postfix and CRLF. Unlike the previous generation, it honours per-beat backpressure, coalesces changes that arrive while a message is in flight, and supports hex, binary or raw value formatting for any GPIO width.

Parameters:
GPIO_WIDTH, 8, number of GPIO pins (1..64)
DEBOUNCE_LENGTH, 15, consecutive stable cycles required before a debounced pin updates (>=1)
PREFIX_CHARS, 31, prefix length in bytes (0 allowed)
PREFIX_STRING, "SWITCHES CHANGED! NEW VALUE: 0x", prefix text; leftmost character is sent first
POSTFIX_CHARS, 0, postfix length in bytes (0 allowed)
POSTFIX_STRING, "", postfix text; leftmost character is sent first
INCLUDE_CRLF, 1, append 0x0D then 0x0A after the postfix
FORMAT, 0, value format: 0 = uppercase hex ASCII; 1 = binary ASCII '0'/'1'; 2 = raw bytes
PACKET_PADDING, 5, idle cycles forced after each tlast (0 = none)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
gpio_in  in  GPIO_WIDTH  raw pins, already synchronised upstream
m_axis_data  out  8  stream byte
m_axis_valid  out  1  byte valid
m_axis_last  out  1  final byte of message
m_axis_tuser  out  12  total message length in bytes (constant)
m_axis_ready  in  1  downstream ready
gpio_debounced  out  GPIO_WIDTH  current debounced value
coalesced_count  out  16  changes merged into a later message; saturating

Behaviour:
- Reset: async assert, sync release. While reset is asserted: valid=0, last=0, data=0, gpio_debounced=0, coalesced_count=0, FSM=IDLE, last_sent snapshot=0.
- Debounce, per pin:
  - A counter increments while the raw pin differs from the debounced pin; it clears when they match.
  - When the counter reaches DEBOUNCE_LENGTH, the debounced pin takes the raw value and the counter clears.
- DATA_LEN by format:
  - FORMAT 0: ceil(W/4) bytes.
  - FORMAT 1: W bytes.
  - FORMAT 2: ceil(W/8) bytes.
  - The value is zero-extended and sent MSB digit/byte first. Hex digits use '0'-'9' and 'A'-'F'.
- POST_LEN = POSTFIX_CHARS + 2*INCLUDE_CRLF.
- m_axis_tuser = PREFIX_CHARS + DATA_LEN + POST_LEN, held constant out of reset.
- FSM states: IDLE, PREFIX, DATA, POSTFIX, GAP.
- IDLE:
  - If gpio_debounced != last_sent, capture snapshot = last_sent = gpio_debounced.
  - Go to the first non-empty state among PREFIX, DATA, POSTFIX.
  - valid rises the cycle after capture.
- PREFIX / DATA / POSTFIX:
  - valid=1 throughout.
  - A beat completes only on valid && ready; the byte index then advances.
  - After the last byte of a state, move to the next non-empty state, or to GAP after the final byte.
- Backpressure: while ready=0, data, last and valid hold stable. valid never drops mid-message.
- m_axis_last = 1 only on the final byte of the message, concurrent with valid.
- GAP:
  - valid=0 for exactly PACKET_PADDING cycles, then IDLE.
  - With PACKET_PADDING=0, go straight to IDLE.
- Coalescing:
  - The message carries the captured snapshot only; gpio changes after capture do not alter it.
  - On return to IDLE, a differing debounced value starts a new message.
  - coalesced_count increments (saturating at 0xFFFF) whenever gpio_debounced changes while FSM != IDLE and a change is already pending (debounced != last_sent, evaluated on the previous cycle).
- Back-to-back messages: throughput is one byte per cycle with ready=1, plus PACKET_PADDING + 1 cycles between messages.
- Reset mid-message: output drops immediately (truncated packet, no tlast). After release the block returns to IDLE with last_sent=0.

Test Plan:
- W=8, FORMAT 0, defaults: after reset, hold gpio_in=0xA5 stable for 15+ cycles → 35 bytes sent: prefix, 'A'(0x41), '5'(0x35), 0x0D, 0x0A. tuser=35; last=1 only on the 0x0A beat; then 5 cycles with valid=0.
- Glitch: pulse one pin for 14 cycles → gpio_debounced unchanged, no message. Pulse for 15 cycles → message sent.
- Backpressure: during the same message, toggle ready randomly (~50%) → same 35 bytes in order, with data/last stable while ready=0.
- Coalesce: mid-message change gpio to 0x01, then 0x02 (each debounced) → second message reports "02", coalesced_count=1, exactly two messages total.
- W=2, FORMAT 1, PREFIX_CHARS=0, INCLUDE_CRLF=0, PACKET_PADDING=0: gpio=2'b10 → 2-byte message "1","0" with tuser=2 and last on "0". W=12, FORMAT 2: value 0xABC → bytes 0x0A, 0xBC.
- Assert reset_n low on byte 10 → valid=0 in the same cycle. After release, gpio=0xA5 still differs from last_sent=0 → a complete fresh message is sent.

Source files
------------

// File: rtl/gpio_msg_axis.sv
// gpio_msg_axis: debounces a GPIO bus and reports every change of the
// debounced value as one framed message on an 8-bit AXI-Stream master.
// Message layout: prefix string, formatted value, postfix string, CRLF.
// Changes that land while a message is in flight are merged into the
// next message and counted in coalesced_count.

module gpio_msg_axis #(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_LENGTH = 15,
  parameter int PREFIX_CHARS    = 31,
  parameter     PREFIX_STRING   = "SWITCHES CHANGED! NEW VALUE: 0x",
  parameter int POSTFIX_CHARS   = 0,
  parameter     POSTFIX_STRING  = "",
  parameter int INCLUDE_CRLF    = 1,
  parameter int FORMAT          = 0,
  parameter int PACKET_PADDING  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [7:0]            m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  output logic [11:0]           m_axis_tuser,
  input  logic                  m_axis_ready,
  output logic [GPIO_WIDTH-1:0] gpio_debounced,
  output logic [15:0]           coalesced_count
);

  // Number of value bytes for the chosen format (hex digits, bits or raw bytes).
  localparam int DATA_LEN = (FORMAT == 0) ? (GPIO_WIDTH + 3) / 4 :
                            (FORMAT == 1) ? GPIO_WIDTH :
                                            (GPIO_WIDTH + 7) / 8;
  localparam int POST_LEN = POSTFIX_CHARS + ((INCLUDE_CRLF != 0) ? 2 : 0);
  localparam int MSG_LEN  = PREFIX_CHARS + DATA_LEN + POST_LEN;

  // Strings are packed with the first character in the most significant byte.
  localparam int PRE_W  = $bits(PREFIX_STRING);
  localparam int POST_W = $bits(POSTFIX_STRING);
  localparam logic [PRE_W-1:0]  PRE_VEC  = PREFIX_STRING;
  localparam logic [POST_W-1:0] POST_VEC = POSTFIX_STRING;

  // The debounce counter only ever holds 0..DEBOUNCE_LENGTH-1.
  localparam int CW = (DEBOUNCE_LENGTH > 1) ? $clog2(DEBOUNCE_LENGTH) : 1;
  localparam int GW = (PACKET_PADDING > 1) ? $clog2(PACKET_PADDING) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    DATA,
    POSTFIX,
    GAP
  } state_t;

  state_t                state, state_next;
  logic [11:0]           idx, idx_next;
  logic [GW-1:0]         gap_cnt, gap_next;
  logic                  capture;
  logic                  beat;
  logic                  sending;

  logic [GPIO_WIDTH-1:0] deb_q, deb_next;
  logic [CW-1:0]         cnt_q    [GPIO_WIDTH];
  logic [CW-1:0]         cnt_next [GPIO_WIDTH];

  // snapshot doubles as the last_sent value: it only changes at capture.
  logic [GPIO_WIDTH-1:0] snapshot;
  logic [63:0]           snap_ext;
  logic [15:0]           coal_q;

  assign gpio_debounced  = deb_q;
  assign coalesced_count = coal_q;
  assign m_axis_tuser    = 12'(MSG_LEN);
  assign snap_ext        = 64'(snapshot);

  // Character idx of the prefix, leftmost character first.
  function automatic logic [7:0] prefix_byte(input logic [11:0] i);
    logic [PRE_W-1:0] sh;
    sh = PRE_VEC >> (8 * (PREFIX_CHARS - 1 - int'(i)));
    return sh[7:0];
  endfunction

  // Character idx of the trailer: postfix string followed by CR LF.
  function automatic logic [7:0] postfix_byte(input logic [11:0] i);
    logic [POST_W-1:0] sh;
    if (int'(i) < POSTFIX_CHARS) begin
      sh = POST_VEC >> (8 * (POSTFIX_CHARS - 1 - int'(i)));
      return sh[7:0];
    end else if (int'(i) == POSTFIX_CHARS) begin
      return 8'h0D;
    end else begin
      return 8'h0A;
    end
  endfunction

  // Value byte idx of the snapshot, most significant digit/byte first.
  function automatic logic [7:0] data_byte(input logic [11:0] i, input logic [63:0] v);
    logic [63:0] sh;
    logic [3:0]  nib;
    int          sel;
    sel = DATA_LEN - 1 - int'(i);
    if (FORMAT == 0) begin
      sh  = v >> (4 * sel);
      nib = sh[3:0];
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (FORMAT == 1) begin
      sh = v >> sel;
      return {7'b0011000, sh[0]};
    end else begin
      sh = v >> (8 * sel);
      return sh[7:0];
    end
  endfunction

  // Per-pin debounce: count consecutive disagreeing samples, adopt the raw value on the last one.
  always_comb begin
    deb_next = deb_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (gpio_in[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_LENGTH - 1)) begin
          deb_next[i] = gpio_in[i];
        end else begin
          cnt_next[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounced value and counters register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_next;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  // Count changes that get merged: busy, a change already pending, and the debounced value moves again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coal_q <= '0;
    end else if ((deb_next != deb_q) && (state != IDLE) && (deb_q != snapshot) &&
                 (coal_q != 16'hFFFF)) begin
      coal_q <= coal_q + 16'd1;
    end
  end

  assign sending = (state == PREFIX) || (state == DATA) || (state == POSTFIX);
  assign beat    = sending && m_axis_ready;

  // Next-state logic: byte index advances only on a completed handshake.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    gap_next   = gap_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (deb_q != snapshot) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = (PREFIX_CHARS > 0) ? PREFIX : DATA;
        end
      end
      PREFIX: begin
        if (beat) begin
          if (idx == 12'(PREFIX_CHARS - 1)) begin
            idx_next   = '0;
            state_next = DATA;
          end else begin
            idx_next = idx + 12'd1;
          end
        end
      end
      DATA: begin
        if (beat) begin
          if (idx == 12'(DATA_LEN - 1)) begin
            idx_next = '0;
            gap_next = '0;
            if (POST_LEN > 0) begin
              state_next = POSTFIX;
            end else if (PACKET_PADDING > 0) begin
              state_next = GAP;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + 12'd1;
          end
        end
      end
      POSTFIX: begin
        if (beat) begin
          if (idx == 12'(POST_LEN - 1)) begin
            idx_next   = '0;
            gap_next   = '0;
            state_next = (PACKET_PADDING > 0) ? GAP : IDLE;
          end else begin
            idx_next = idx + 12'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GW'(PACKET_PADDING - 1)) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        gap_next   = '0;
      end
    endcase
  end

  // State, index, gap counter and captured snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      gap_cnt  <= '0;
      snapshot <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      gap_cnt <= gap_next;
      if (capture) begin
        snapshot <= deb_q;
      end
    end
  end

  // Stream outputs decode purely from registers, so they hold still while ready is low.
  always_comb begin
    m_axis_valid = sending;
    m_axis_data  = 8'h00;
    m_axis_last  = 1'b0;
    case (state)
      PREFIX: begin
        m_axis_data = prefix_byte(idx);
      end
      DATA: begin
        m_axis_data = data_byte(idx, snap_ext);
        m_axis_last = (POST_LEN == 0) && (idx == 12'(DATA_LEN - 1));
      end
      POSTFIX: begin
        m_axis_data = postfix_byte(idx);
        m_axis_last = (idx == 12'(POST_LEN - 1));
      end
      default: begin
        m_axis_data = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_msg_axis.sv
// tb_gpio_msg_axis: directed and randomized checks of gpio_msg_axis against a
// message-level reference model (byte queue plus gap counter).

module tb_gpio_msg_axis;

  localparam int DEB = 15;
  localparam int PAD = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  gpio;
  logic        ready;
  logic [7:0]  data;
  logic        valid, last;
  logic [11:0] tuser;
  logic [7:0]  deb;
  logic [15:0] coal;

  logic        ready_aux = 1'b1;
  logic [1:0]  gpio2;
  logic [7:0]  data2;
  logic        valid2, last2;
  logic [11:0] tuser2;
  logic [1:0]  deb2;
  logic [15:0] coal2;

  logic [11:0] gpio3;
  logic [7:0]  data3;
  logic        valid3, last3;
  logic [11:0] tuser3;
  logic [11:0] deb3;
  logic [15:0] coal3;

  always #5 clk = ~clk;

  gpio_msg_axis dut (
    .clk(clk), .reset_n(reset_n), .gpio_in(gpio),
    .m_axis_data(data), .m_axis_valid(valid), .m_axis_last(last),
    .m_axis_tuser(tuser), .m_axis_ready(ready),
    .gpio_debounced(deb), .coalesced_count(coal)
  );

  gpio_msg_axis #(
    .GPIO_WIDTH(2), .DEBOUNCE_LENGTH(4), .PREFIX_CHARS(0), .INCLUDE_CRLF(0),
    .FORMAT(1), .PACKET_PADDING(0)
  ) dut_bin (
    .clk(clk), .reset_n(reset_n), .gpio_in(gpio2),
    .m_axis_data(data2), .m_axis_valid(valid2), .m_axis_last(last2),
    .m_axis_tuser(tuser2), .m_axis_ready(ready_aux),
    .gpio_debounced(deb2), .coalesced_count(coal2)
  );

  gpio_msg_axis #(
    .GPIO_WIDTH(12), .DEBOUNCE_LENGTH(3), .PREFIX_CHARS(2), .PREFIX_STRING("V:"),
    .POSTFIX_CHARS(1), .POSTFIX_STRING("!"), .INCLUDE_CRLF(1),
    .FORMAT(2), .PACKET_PADDING(2)
  ) dut_raw (
    .clk(clk), .reset_n(reset_n), .gpio_in(gpio3),
    .m_axis_data(data3), .m_axis_valid(valid3), .m_axis_last(last3),
    .m_axis_tuser(tuser3), .m_axis_ready(ready_aux),
    .gpio_debounced(deb3), .coalesced_count(coal3)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  string      prefix_s = "SWITCHES CHANGED! NEW VALUE: 0x";
  string      hex_s    = "0123456789ABCDEF";
  logic [7:0] exp_q[$];
  int         gap_left;
  logic [7:0] m_deb, m_last;
  int         m_cnt[8];
  int         m_coal;

  // Received beats as {last, data}.
  logic [8:0] rx_cur[$];
  logic [8:0] rx_msg[$];
  logic [8:0] rx2[$];
  logic [8:0] rx3[$];
  int         msgs = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    gap_left = 0;
    m_deb    = 8'h00;
    m_last   = 8'h00;
    m_coal   = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic build_msg(input logic [7:0] v);
    for (int i = 0; i < prefix_s.len(); i++) exp_q.push_back(prefix_s[i]);
    exp_q.push_back(hex_s[v[7:4]]);
    exp_q.push_back(hex_s[v[3:0]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One clock cycle: compare outputs with the model, record beats, advance the model.
  task automatic tick();
    logic [7:0] new_deb;
    logic [7:0] e_data;
    bit         idle_now;
    #1;
    e_data = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    checkOutput("valid", {63'd0, valid}, {63'd0, exp_q.size() > 0});
    checkOutput("data", {56'd0, data}, {56'd0, e_data});
    checkOutput("last", {63'd0, last}, {63'd0, exp_q.size() == 1});
    checkOutput("debounced", {56'd0, deb}, {56'd0, m_deb});
    checkOutput("coalesced", {48'd0, coal}, 64'(m_coal));
    if (valid && ready) begin
      rx_cur.push_back({last, data});
      if (last) begin
        rx_msg = rx_cur;
        rx_cur.delete();
        msgs++;
      end
    end
    if (valid2) rx2.push_back({last2, data2});
    if (valid3) rx3.push_back({last3, data3});
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      idle_now = (exp_q.size() == 0) && (gap_left == 0);
      new_deb  = m_deb;
      for (int i = 0; i < 8; i++) begin
        if (gpio[i] != m_deb[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            new_deb[i] = gpio[i];
            m_cnt[i]   = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
      if ((new_deb != m_deb) && !idle_now && (m_deb != m_last) && (m_coal < 65535)) m_coal++;
      if (exp_q.size() > 0) begin
        if (ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) gap_left = PAD;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (m_deb != m_last) begin
        m_last = m_deb;
        build_msg(m_deb);
      end
      m_deb = new_deb;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] g, input logic r, input int n);
    gpio  = g;
    ready = r;
    repeat (n) tick();
  endtask

  task automatic runRandomReady(input logic [7:0] g, input int n);
    gpio = g;
    repeat (n) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic waitValid(input int bound);
    int k = 0;
    while (!valid && k < bound) begin
      tick();
      k++;
    end
    checkOutput("wait_valid_timeout", {63'd0, valid}, 64'd1);
  endtask

  task automatic checkMsgValue(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    checkOutput({tag, "_len"}, 64'(rx_msg.size()), 64'd35);
    if (rx_msg.size() == 35) begin
      checkOutput({tag, "_first"}, 64'(rx_msg[0]), 64'h053);
      checkOutput({tag, "_hi"}, 64'(rx_msg[31]), {56'd0, hi});
      checkOutput({tag, "_lo"}, 64'(rx_msg[32]), {56'd0, lo});
      checkOutput({tag, "_cr"}, 64'(rx_msg[33]), 64'h00D);
      checkOutput({tag, "_lf_last"}, 64'(rx_msg[34]), 64'h10A);
    end
  endtask

  initial begin
    logic [8:0] e3[7];
    logic [8:0] got;
    e3 = '{9'h056, 9'h03A, 9'h00A, 9'h0BC, 9'h021, 9'h00D, 9'h10A};

    reset_n = 1'b0;
    gpio    = 8'h00;
    ready   = 1'b1;
    gpio2   = 2'b10;
    gpio3   = 12'hABC;
    model_reset();
    @(negedge clk);
    repeat (3) tick();
    checkOutput("tuser", 64'(tuser), 64'd35);
    checkOutput("tuser_bin", 64'(tuser2), 64'd2);
    checkOutput("tuser_raw", 64'(tuser3), 64'd7);
    reset_n = 1'b1;

    // First message: 0xA5 held stable.
    applyStimulus(8'hA5, 1'b1, 120);
    checkOutput("msgs_a5", 64'(msgs), 64'd1);
    checkMsgValue("msg_a5", 8'h41, 8'h35);

    // Narrow-bus binary and 12-bit raw variants.
    checkOutput("bin_len", 64'(rx2.size()), 64'd2);
    got = (rx2.size() > 0) ? rx2[0] : 9'h1FF;
    checkOutput("bin_b0", 64'(got), 64'h031);
    got = (rx2.size() > 1) ? rx2[1] : 9'h1FF;
    checkOutput("bin_b1_last", 64'(got), 64'h130);
    checkOutput("raw_len", 64'(rx3.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      got = (i < rx3.size()) ? rx3[i] : 9'h1FF;
      checkOutput($sformatf("raw_b%0d", i), 64'(got), 64'(e3[i]));
    end

    // Glitch of 14 cycles is filtered; 15 cycles gets through and then reverts.
    applyStimulus(8'hA4, 1'b1, 14);
    applyStimulus(8'hA5, 1'b1, 40);
    checkOutput("glitch14_msgs", 64'(msgs), 64'd1);
    applyStimulus(8'hA4, 1'b1, 15);
    applyStimulus(8'hA5, 1'b1, 150);
    checkOutput("glitch15_msgs", 64'(msgs), 64'd3);
    checkMsgValue("msg_revert", 8'h41, 8'h35);

    // Random backpressure on a full message.
    runRandomReady(8'h5A, 250);
    ready = 1'b1;
    applyStimulus(8'h5A, 1'b1, 20);
    checkOutput("bp_msgs", 64'(msgs), 64'd4);
    checkMsgValue("msg_bp", 8'h35, 8'h41);

    // Two changes while a message is stalled collapse into one follow-up.
    applyStimulus(8'h3C, 1'b0, 1);
    waitValid(40);
    applyStimulus(8'h01, 1'b0, 20);
    applyStimulus(8'h02, 1'b0, 20);
    applyStimulus(8'h02, 1'b1, 150);
    checkOutput("coal_msgs", 64'(msgs), 64'd6);
    checkOutput("coal_count", 64'(coal), 64'd1);
    checkMsgValue("msg_coal", 8'h30, 8'h32);

    // Reset on the tenth byte truncates the packet; a fresh one follows.
    gpio  = 8'hA5;
    ready = 1'b1;
    waitValid(40);
    begin
      int k = 0;
      while (rx_cur.size() < 9 && k < 60) begin
        tick();
        k++;
      end
    end
    checkOutput("byte10_reached", 64'(rx_cur.size()), 64'd9);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_valid", {63'd0, valid}, 64'd0);
    checkOutput("reset_mid_last", {63'd0, last}, 64'd0);
    model_reset();
    rx_cur.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    applyStimulus(8'hA5, 1'b1, 120);
    checkOutput("reset_msgs", 64'(msgs), 64'd7);
    checkMsgValue("msg_after_reset", 8'h41, 8'h35);

    // Random pins and random ready against the model.
    for (int n = 0; n < 40; n++) begin
      runRandomReady(8'($urandom), $urandom_range(3, 40));
    end
    applyStimulus(gpio, 1'b1, 120);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
